// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle fetch stage issuing one ibus read per PC over a split
// address/data handshake, with misaligned-PC fault reporting and redirect flush.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_valid,
  input  logic [31:0] pc,
  output logic        pc_ready,
  input  logic        flush,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        inst_ready,
  output logic [2:0]  state_dbg
);

  // Handshakes: a PC transfers on a rising edge where pc_valid & pc_ready & !flush; the
  // address transfers where ireq_valid & iresp_addr_ok; data where iresp_data_ok arrives
  // with a read outstanding; the instruction transfers where inst_valid & inst_ready & !flush.
  // flush beats every other input sampled on the same edge.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t state;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      pc_ready   <= 1'b0;
      ireq_valid <= 1'b1;
      ireq_addr  <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!flush && pc_valid) begin
            pc_ready <= 1'b0;
            if (pc[1:0] != 2'b00) begin
              // Misaligned PC never reaches the bus; report the fault directly.
              state      <= S_HOLD;
              inst_valid <= 1'b1;
              inst       <= '0;
              inst_pc    <= pc;
              inst_fault <= 1'b1;
            end else begin
              state      <= S_REQ;
              ireq_valid <= 1'b1;
              ireq_addr  <= pc;
            end
          end
        end

        S_REQ: begin
          if (iresp_addr_ok) begin
            ireq_valid <= 1'b0;
            if (flush) begin
              if (iresp_data_ok) begin
                state    <= S_IDLE;
                pc_ready <= 1'b1;
              end else begin
                state <= S_DRAIN;
              end
            end else if (iresp_data_ok) begin
              state      <= S_HOLD;
              inst_valid <= 1'b1;
              inst       <= iresp_data;
              inst_pc    <= ireq_addr;
              inst_fault <= 1'b0;
            end else begin
              state <= S_WAIT;
            end
          end else if (flush) begin
            // Address not yet taken, so the request can simply be withdrawn.
            state      <= S_IDLE;
            ireq_valid <= 1'b0;
            pc_ready   <= 1'b1;
          end
        end

        S_WAIT: begin
          if (iresp_data_ok) begin
            if (flush) begin
              state    <= S_IDLE;
              pc_ready <= 1'b1;
            end else begin
              state      <= S_HOLD;
              inst_valid <= 1'b1;
              inst       <= iresp_data;
              inst_pc    <= ireq_addr;
              inst_fault <= 1'b0;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end

        S_HOLD: begin
          if (flush || inst_ready) begin
            state      <= S_IDLE;
            inst_valid <= 1'b0;
            pc_ready   <= 1'b1;
          end
        end

        S_DRAIN: begin
          // Swallow the read that was in flight when the flush hit; flush itself is moot here.
          if (iresp_data_ok) begin
            state    <= S_IDLE;
            pc_ready <= 1'b1;
          end
        end

        default: begin
          state      <= S_IDLE;
          pc_ready   <= 1'b1;
          ireq_valid <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
